// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder/subtractor built around a single full adder

// One-bit full adder; the only arithmetic element in the block.
module fullyadder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// Accepts an operand pair, walks it LSB first through the full adder, then pulses done.
module serial_add_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_sr;
  logic [CW-1:0]    cnt;
  logic             carry_q;
  logic             fa_s;
  logic             fa_co;
  logic             last_bit;

  // Subtraction arrives here already as A + ~B + 1, so the adder never knows the mode.
  fullyadder u_fa (
    .a    (a_reg[cnt]),
    .b    (b_reg[cnt]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_co)
  );

  assign last_bit = (cnt == CW'(WIDTH - 1));
  assign busy     = (state == RUN);
  assign done     = (state == DONE);

  // State register; reset wins over everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; start only matters in IDLE, DONE always falls back to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: latch operands on accept, shift one sum bit per RUN cycle, publish on the last bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sum_sr    <= '0;
      cnt       <= '0;
      carry_q   <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg   <= op_a;
            b_reg   <= sub ? ~op_b : op_b;
            carry_q <= sub;
            cnt     <= '0;
          end
        end
        RUN: begin
          // Bits enter at the top and move down, so bit 0 lands in place after WIDTH shifts.
          sum_sr  <= {fa_s, sum_sr[WIDTH-1:1]};
          carry_q <= fa_co;
          cnt     <= cnt + CW'(1);
          if (last_bit) begin
            // result is only touched here, hiding the partial shift contents during RUN.
            result    <= {fa_s, sum_sr[WIDTH-1:1]};
            carry_out <= fa_co;
            // carry_q currently holds the carry into the MSB.
            overflow  <= carry_q ^ fa_co;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - directed self-checking bench for serial_add_ctrl at WIDTH=8

module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;

  int nchecks = 0;
  int nerrors = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sub       (sub),
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation and check latency, busy width, outputs; optionally poke start while busy.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic [W-1:0] exp_r, input logic exp_c,
                        input logic exp_v, input bit poke);
    int n;
    int nbusy;
    int overlap;
    start = 1'b1; sub = s; op_a = a; op_b = b;
    tick();
    start = 1'b0;
    n = 0; nbusy = busy ? 1 : 0; overlap = 0;
    while (n < 20) begin
      if (poke) begin
        start = 1'b1; sub = ~s; op_a = 8'hC3; op_b = 8'h5E;
      end
      tick();
      n++;
      if (busy && done) overlap++;
      if (busy) nbusy++;
      if (done) break;
    end
    check({tag, "_latency"}, n, 8);
    check({tag, "_busy_cycles"}, nbusy, 8);
    check({tag, "_overlap"}, overlap, 0);
    check({tag, "_result"}, result, exp_r);
    check({tag, "_carry"}, carry_out, exp_c);
    check({tag, "_ovf"}, overflow, exp_v);
    // poke leaves start high through the DONE edge; it must still be ignored.
    tick();
    start = 1'b0;
    check({tag, "_idle_after"}, {busy, done}, 2'b00);
    if (poke) begin
      tick();
      check({tag, "_no_requeue"}, {busy, done}, 2'b00);
      check({tag, "_result_hold"}, result, exp_r);
    end
  endtask

  initial begin : stim
    logic [W-1:0] bb_a [3];
    logic [W-1:0] bb_b [3];
    logic         bb_s [3];
    logic [W-1:0] bb_r [3];
    logic         bb_c [3];
    logic         bb_v [3];
    int           k;
    int           cyc;
    int           ndone;

    rst = 1'b1; start = 1'b1; sub = 1'b0; op_a = 8'hFF; op_b = 8'hFF;
    tick(); tick();
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_result", result, 0);
    check("reset_carry", carry_out, 0);
    check("reset_ovf", overflow, 0);
    start = 1'b0;
    rst = 1'b0;
    tick();

    run_op("add", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, 1'b0);
    run_op("wrap", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    run_op("sub1", 8'h10, 8'h01, 1'b1, 8'h0F, 1'b1, 1'b0, 1'b0);
    run_op("sub2", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);
    run_op("reject", 8'h33, 8'h44, 1'b0, 8'h77, 1'b0, 1'b0, 1'b1);

    // Back-to-back with start held high: accepts every 10 cycles.
    bb_a = '{8'h01, 8'h7F, 8'h00};
    bb_b = '{8'h02, 8'h01, 8'h01};
    bb_s = '{1'b0, 1'b0, 1'b1};
    bb_r = '{8'h03, 8'h80, 8'hFF};
    bb_c = '{1'b0, 1'b0, 1'b0};
    bb_v = '{1'b0, 1'b1, 1'b0};
    k = 0; ndone = 0;
    start = 1'b1; op_a = bb_a[0]; op_b = bb_b[0]; sub = bb_s[0];
    for (cyc = 1; cyc <= 32; cyc++) begin
      tick();
      if (done) begin
        check($sformatf("b2b%0d_time", k), cyc, 9 + 10 * k);
        check($sformatf("b2b%0d_result", k), result, bb_r[k]);
        check($sformatf("b2b%0d_flags", k), {carry_out, overflow}, {bb_c[k], bb_v[k]});
        ndone++;
        k++;
        if (k == 3) break;
        op_a = bb_a[k]; op_b = bb_b[k]; sub = bb_s[k];
      end
    end
    check("b2b_count", ndone, 3);
    start = 1'b0;
    tick(); tick();

    // Reset four edges after accept aborts without a done pulse.
    start = 1'b1; sub = 1'b0; op_a = 8'hAA; op_b = 8'h55;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_outputs", {busy, done, carry_out, overflow}, 4'b0000);
    check("abort_result", result, 0);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) ndone++;
    end
    check("abort_no_done", ndone, 0);
    run_op("post_abort", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
